// File: rtl/cpu_imem_pkg.sv
// Shared constants for the instruction memory and its byte-serial loader.
// The loader assembles 48-bit instruction words from 6 bytes, MSB first.
package cpu_imem_pkg;

    localparam int              INSTR_W             = 48;
    localparam logic [47:0]     NOP_INSTR           = 48'h0;
    localparam int              LOAD_BYTES_PER_WORD = 6;

    localparam logic [1:0] IMEM_IDLE     = 2'd0;
    localparam logic [1:0] IMEM_ASSEMBLE = 2'd1;
    localparam logic [1:0] IMEM_COMMIT   = 2'd2;

endpackage

// File: rtl/cpu_imem_if.sv
// Fetch-side hatch bus and runtime loader bus of the instruction memory.
// The master side is fetch plus the loader; the slave side is the memory.
interface cpu_imem_if #(
    parameter int DEPTH_LOG2 = 8
) ();
    import cpu_imem_pkg::*;

    logic [31:0]         hatch_address;
    logic [INSTR_W-1:0]  hatch_instruction;
    logic                load_start;
    logic                load_done;
    logic                load_byte_valid;
    logic [7:0]          load_byte;
    logic                load_byte_ready;
    logic                load_overflow;
    logic [DEPTH_LOG2:0] load_count;
    logic                cpu_hold;

    modport master (
        output hatch_address, load_start, load_done, load_byte_valid, load_byte,
        input  hatch_instruction, load_byte_ready, load_overflow, load_count, cpu_hold
    );

    modport slave (
        input  hatch_address, load_start, load_done, load_byte_valid, load_byte,
        output hatch_instruction, load_byte_ready, load_overflow, load_count, cpu_hold
    );

endinterface

// File: rtl/cpu_imem_loader.sv
// Loader FSM: collects 6 bytes per word, then spends one COMMIT cycle writing it.
// Also owns the session bookkeeping (write pointer, word count, overflow, cpu hold).
module cpu_imem_loader
    import cpu_imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  i_load_start,
    input  logic                  i_load_done,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_overflow,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_cpu_hold,
    output logic                  o_we,
    output logic [DEPTH_LOG2-1:0] o_waddr,
    output logic [INSTR_W-1:0]    o_wdata
);

    localparam logic [DEPTH_LOG2:0] COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [2:0]          LAST_BYTE = 3'(LOAD_BYTES_PER_WORD - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [2:0]            r_byte_idx;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [INSTR_W-1:0]    r_asm;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_hold;
    logic                  w_accept;

    // load_done wins over a byte offered in the same cycle
    assign o_byte_ready = (r_state == IMEM_ASSEMBLE) && !i_load_done;
    assign w_accept     = o_byte_ready && i_byte_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IMEM_IDLE:     if (i_load_start) w_next_state = IMEM_ASSEMBLE;
            IMEM_ASSEMBLE: begin
                if (i_load_done)
                    w_next_state = IMEM_IDLE;
                else if (w_accept && (r_byte_idx == LAST_BYTE))
                    w_next_state = IMEM_COMMIT;
            end
            IMEM_COMMIT:   w_next_state = i_load_done ? IMEM_IDLE : IMEM_ASSEMBLE;
            default:       w_next_state = IMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= IMEM_IDLE;
            r_byte_idx <= '0;
            r_wptr     <= '0;
            r_asm      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_hold  <= (w_next_state != IMEM_IDLE);
            case (r_state)
                IMEM_IDLE: begin
                    if (i_load_start) begin
                        r_wptr     <= '0;
                        r_byte_idx <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                IMEM_ASSEMBLE: begin
                    if (i_load_done) begin
                        r_byte_idx <= '0;
                    end else if (w_accept) begin
                        r_asm      <= {r_asm[INSTR_W-9:0], i_byte};
                        r_byte_idx <= r_byte_idx + 3'd1;
                    end
                end
                IMEM_COMMIT: begin
                    r_wptr     <= r_wptr + 1'b1;
                    r_byte_idx <= '0;
                    if (&r_wptr)
                        r_overflow <= 1'b1;
                    if (r_count != COUNT_MAX)
                        r_count <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_overflow = r_overflow;
    assign o_count    = r_count;
    assign o_cpu_hold = r_hold;
    assign o_we       = (r_state == IMEM_COMMIT);
    assign o_waddr    = r_wptr;
    assign o_wdata    = r_asm;

endmodule

// File: rtl/cpu_imem.sv
// Instruction memory with a zero-latency read for fetch and a runtime byte loader.
// Words never written since reset read back as NOP.
module cpu_imem
    import cpu_imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst_b,
    cpu_imem_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [INSTR_W-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic [INSTR_W-1:0]    w_wdata;
    logic [DEPTH_LOG2-1:0] w_ridx;
    logic                  w_in_range;
    logic [1:0]            w_unused_addr_lo;

    cpu_imem_loader #(.DEPTH_LOG2(DEPTH_LOG2)) u_loader (
        .clk          (clk),
        .rst_b        (rst_b),
        .i_load_start (bus.load_start),
        .i_load_done  (bus.load_done),
        .i_byte_valid (bus.load_byte_valid),
        .i_byte       (bus.load_byte),
        .o_byte_ready (bus.load_byte_ready),
        .o_overflow   (bus.load_overflow),
        .o_count      (bus.load_count),
        .o_cpu_hold   (bus.cpu_hold),
        .o_we         (w_we),
        .o_waddr      (w_waddr),
        .o_wdata      (w_wdata)
    );

    // Only the valid bits are reset; the data array itself is plain storage
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            r_valid <= '0;
        else if (w_we)
            r_valid[w_waddr] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    assign w_unused_addr_lo      = bus.hatch_address[1:0];
    assign w_ridx                = bus.hatch_address[DEPTH_LOG2+1:2];
    assign w_in_range            = (bus.hatch_address[31:DEPTH_LOG2+2] == '0);
    assign bus.hatch_instruction = (w_in_range && r_valid[w_ridx]) ? r_mem[w_ridx] : NOP_INSTR;

endmodule

// File: tb/tb_cpu_imem.sv
// Directed-sequence bench for cpu_imem with randomized load data and a
// word-level reference model of memory contents and session counters.
module tb_cpu_imem;
    import cpu_imem_pkg::*;

    localparam int DEPTH_LOG2 = 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    cpu_imem_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    cpu_imem #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [47:0] refMem [DEPTH];
    bit          refValid [DEPTH];
    int          refCount;
    int          refWptr;
    bit          refOvf;
    logic [47:0] refAsm;
    int          refIdx;
    logic [47:0] lastOld;
    logic [47:0] lastWord;

    function automatic logic [47:0] refRead(input logic [31:0] a);
        int slot;
        if (a >= 32'(4 * DEPTH)) return 48'h0;
        slot = int'(a / 4);
        return refValid[slot] ? refMem[slot] : 48'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic done, input logic valid, input logic [7:0] b);
        bus.load_start      = start;
        bus.load_done       = done;
        bus.load_byte_valid = valid;
        bus.load_byte       = b;
        tick();
        bus.load_start      = 1'b0;
        bus.load_done       = 1'b0;
        bus.load_byte_valid = 1'b0;
    endtask

    task automatic readAt(input logic [31:0] a, output logic [47:0] v);
        bus.hatch_address = a;
        #1;
        v = bus.hatch_instruction;
    endtask

    task automatic startLoad();
        refWptr  = 0;
        refCount = 0;
        refOvf   = 0;
        refIdx   = 0;
        refAsm   = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic finishLoad();
        refIdx = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // Offers one byte until accepted; returns the number of cycles spent waiting for ready
    task automatic sendByte(input logic [7:0] b, output int waits);
        int slot;
        waits = 0;
        bus.load_byte_valid = 1'b1;
        bus.load_byte       = b;
        while (!bus.load_byte_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (waits >= 20) checkOutput("ready_timeout", 64'(bus.load_byte_ready), 64'd1);
        tick();
        bus.load_byte_valid = 1'b0;
        checkOutput("hold_during_load", 64'(bus.cpu_hold), 64'd1);
        refAsm = (refAsm << 8) | 48'(b);
        refIdx++;
        if (refIdx == LOAD_BYTES_PER_WORD) begin
            slot           = refWptr;
            lastOld        = refRead(32'(slot * 4));
            lastWord       = refAsm;
            refMem[slot]   = refAsm;
            refValid[slot] = 1'b1;
            refWptr        = (refWptr + 1) % DEPTH;
            if (refWptr == 0) refOvf = 1'b1;
            refCount       = (refCount + 1 > DEPTH) ? DEPTH : refCount + 1;
            refIdx         = 0;
        end
    endtask

    task automatic sendWord(input logic [47:0] w);
        int wt;
        for (int i = 0; i < LOAD_BYTES_PER_WORD; i++)
            sendByte(w[47 - 8 * i -: 8], wt);
    endtask

    task automatic checkMemory(input string tag);
        logic [47:0] v;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'(i * 4) | 32'($urandom_range(0, 3));
            readAt(a, v);
            checkOutput(tag, 64'(v), 64'(refRead(a)));
        end
    endtask

    function automatic logic [47:0] randWord();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [47:0] v;
        logic [47:0] w;
        int          wt;
        int          expWait;

        rst_b               = 1'b0;
        bus.hatch_address   = '0;
        bus.load_start      = 1'b0;
        bus.load_done       = 1'b0;
        bus.load_byte_valid = 1'b0;
        bus.load_byte       = '0;
        for (int i = 0; i < DEPTH; i++) refValid[i] = 1'b0;
        refCount = 0; refWptr = 0; refOvf = 0; refIdx = 0; refAsm = '0;

        #12;
        checkOutput("reset_hold",     64'(bus.cpu_hold),        64'd0);
        checkOutput("reset_ready",    64'(bus.load_byte_ready), 64'd0);
        checkOutput("reset_overflow", 64'(bus.load_overflow),   64'd0);
        checkOutput("reset_count",    64'(bus.load_count),      64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        $display("[TB] post-reset sweep");
        checkMemory("reset_sweep");

        $display("[TB] two-word load 0x01..0x0C");
        startLoad();
        checkOutput("start_hold",  64'(bus.cpu_hold),   64'd1);
        checkOutput("start_count", 64'(bus.load_count), 64'd0);
        for (int i = 1; i <= 12; i++) begin
            sendByte(8'(i), wt);
            expWait = (i == 7) ? 1 : 0;
            checkOutput("ready_wait", 64'(wt), 64'(expWait));
            if (i == 6 || i == 12)
                checkOutput("ready_commit", 64'(bus.load_byte_ready), 64'd0);
        end
        tick();
        checkOutput("hold_before_done", 64'(bus.cpu_hold), 64'd1);
        finishLoad();
        checkOutput("hold_after_done", 64'(bus.cpu_hold),   64'd0);
        checkOutput("count_two",       64'(bus.load_count), 64'd2);
        readAt(32'h0, v); checkOutput("word0_fixed", 64'(v), 64'h010203040506);
        readAt(32'h4, v); checkOutput("word1_fixed", 64'(v), 64'h0708090A0B0C);
        readAt(32'h8, v); checkOutput("word2_nop",   64'(v), 64'h0);

        $display("[TB] partial-word load with done colliding with a byte");
        startLoad();
        for (int i = 0; i < 8; i++) sendByte(8'($urandom), wt);
        bus.load_byte_valid = 1'b1;
        bus.load_byte       = 8'hEE;
        bus.load_done       = 1'b1;
        #1;
        checkOutput("ready_vs_done", 64'(bus.load_byte_ready), 64'd0);
        tick();
        bus.load_byte_valid = 1'b0;
        bus.load_done       = 1'b0;
        refIdx = 0;
        checkOutput("partial_count", 64'(bus.load_count), 64'(refCount));
        checkOutput("partial_hold",  64'(bus.cpu_hold),   64'd0);
        readAt(32'h0, v); checkOutput("partial_word0", 64'(v), 64'(refRead(32'h0)));
        readAt(32'h4, v); checkOutput("stale_word1",   64'(v), 64'h0708090A0B0C);

        $display("[TB] 257-word wrap load");
        startLoad();
        checkOutput("wrap_ovf_start", 64'(bus.load_overflow), 64'd0);
        for (int i = 0; i < DEPTH + 1; i++) sendWord(randWord());
        finishLoad();
        checkOutput("wrap_overflow", 64'(bus.load_overflow), 64'(refOvf));
        checkOutput("wrap_ovf_set",  64'(bus.load_overflow), 64'd1);
        checkOutput("wrap_count",    64'(bus.load_count),    64'(DEPTH));
        readAt(32'h0, v); checkOutput("word0_is_257th", 64'(v), 64'(lastWord));
        checkMemory("wrap_sweep");
        readAt(32'h400, v); checkOutput("above_depth_400", 64'(v), 64'h0);
        for (int i = 0; i < 8; i++) begin
            w = 48'($urandom_range(32'h401, 32'hFFFF_FFFF));
            readAt(w[31:0], v);
            checkOutput("above_depth_rand", 64'(v), 64'h0);
        end

        $display("[TB] commit-cycle read collision at 0x10");
        startLoad();
        checkOutput("ovf_cleared",   64'(bus.load_overflow), 64'd0);
        checkOutput("count_cleared", 64'(bus.load_count),    64'd0);
        for (int i = 0; i < 4; i++) sendWord(randWord());
        w = randWord();
        sendWord(w);
        readAt(32'h10, v); checkOutput("collide_old", 64'(v), 64'(lastOld));
        tick();
        readAt(32'h10, v); checkOutput("collide_new", 64'(v), 64'(w));
        finishLoad();
        checkOutput("collide_count", 64'(bus.load_count), 64'd5);

        $display("[TB] reset in the middle of word 5");
        startLoad();
        for (int i = 0; i < 5; i++) sendWord(randWord());
        for (int i = 0; i < 3; i++) sendByte(8'($urandom), wt);
        #2;
        rst_b = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) refValid[i] = 1'b0;
        refCount = 0; refOvf = 0; refIdx = 0; refWptr = 0;
        checkOutput("midreset_hold",  64'(bus.cpu_hold),        64'd0);
        checkOutput("midreset_ready", 64'(bus.load_byte_ready), 64'd0);
        checkOutput("midreset_count", 64'(bus.load_count),      64'd0);
        checkMemory("midreset_sweep");
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        startLoad();
        w = randWord();
        sendWord(w);
        tick();
        finishLoad();
        checkOutput("reload_count", 64'(bus.load_count), 64'd1);
        readAt(32'h0, v); checkOutput("reload_word0", 64'(v), 64'(w));
        readAt(32'h4, v); checkOutput("reload_word1", 64'(v), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
